truth_table_checker: RTL

// Response-checking end of the exhaustive truth-table sweep used on our combinational circuits.
// - A stimulus source applies input vectors 0..2**N_IN-1 in ascending order to a DUT.
// - This block receives each applied vector together with the DUT outputs.
// - It compares the outputs against a parameterised golden table, counts errors, and records
//   the first failure.
// - It reports pass/fail at the end of the sweep, or a timeout if the stimulus source stalls.

---
 rtl/truth_table_checker_if.sv | 14 +
 rtl/truth_table_checker.sv | 104 ++++++++++
 2 files changed

// File: rtl/truth_table_checker_if.sv
// Sample bus between the sweep stimulus source and the response checker:
// sweep start strobe plus the applied vector and the DUT outputs observed for it.
interface truth_table_checker_if #(
   parameter int unsigned N_IN  = 3,
   parameter int unsigned N_OUT = 2
);
   logic             start;
   logic             vec_valid;
   logic [N_IN-1:0]  vec;
   logic [N_OUT-1:0] obs;

   modport master (output start, output vec_valid, output vec, output obs);
   modport slave  (input  start, input  vec_valid, input  vec, input  obs);
endinterface

// File: rtl/truth_table_checker.sv
// Response checker for an exhaustive ascending truth-table sweep: compares each
// observed output against a golden table, counts errors, captures the first failure.
module truth_table_checker #(
   parameter int unsigned                    N_IN     = 3,
   parameter int unsigned                    N_OUT    = 2,
   parameter logic [(2**N_IN)*N_OUT-1:0]     EXPECTED = 16'hD668,
   parameter int unsigned                    TIMEOUT  = 64,
   parameter int unsigned                    CW       = $clog2(2**N_IN+1)
) (
   input  logic                clk,
   input  logic                rst_n,
   truth_table_checker_if.slave bus,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic                seq_err,
   output logic [CW-1:0]       err_count,
   output logic [N_IN-1:0]     first_fail_vec,
   output logic [N_OUT-1:0]    first_fail_obs,
   output logic                first_fail_valid
);
   localparam int unsigned NVEC = 2**N_IN;
   localparam int unsigned TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT+1) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [N_IN-1:0]  idx;
   logic [TW-1:0]    idle_cnt;
   logic [N_OUT-1:0] exp_obs;
   logic             out_of_order;
   logic             sample_fail;
   logic             last;
   logic             idle_expired;
   logic [CW-1:0]    err_next;

   // The golden entry is selected by the expected index, never by the received vec.
   always_comb begin
      exp_obs      = EXPECTED[32'(idx) * N_OUT +: N_OUT];
      out_of_order = (bus.vec != idx);
      sample_fail  = out_of_order || (bus.obs != exp_obs);
      err_next     = err_count + CW'(sample_fail);
      last         = (idx == N_IN'(NVEC - 1));
      idle_expired = (TIMEOUT != 0) && ((32'(idle_cnt) + 32'd1) >= TIMEOUT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state            <= IDLE;
         idx              <= '0;
         idle_cnt         <= '0;
         busy             <= 1'b0;
         done             <= 1'b0;
         pass             <= 1'b0;
         timeout          <= 1'b0;
         seq_err          <= 1'b0;
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_obs   <= '0;
         first_fail_valid <= 1'b0;
      end else if (bus.start) begin
         // Start from any state (including a restart in RUN) discards the current cycle's sample.
         state            <= RUN;
         idx              <= '0;
         idle_cnt         <= '0;
         busy             <= 1'b1;
         done             <= 1'b0;
         pass             <= 1'b0;
         timeout          <= 1'b0;
         seq_err          <= 1'b0;
         err_count        <= '0;
         first_fail_vec   <= '0;
         first_fail_obs   <= '0;
         first_fail_valid <= 1'b0;
      end else if (state == RUN) begin
         if (bus.vec_valid) begin
            idx       <= idx + 1'b1;
            idle_cnt  <= '0;
            err_count <= err_next;
            seq_err   <= seq_err | out_of_order;
            if (sample_fail && !first_fail_valid) begin
               first_fail_vec   <= bus.vec;
               first_fail_obs   <= bus.obs;
               first_fail_valid <= 1'b1;
            end
            if (last) begin
               state <= DONE;
               busy  <= 1'b0;
               done  <= 1'b1;
               pass  <= (err_next == '0) && !(seq_err || out_of_order);
            end
         end else if (idle_expired) begin
            state   <= DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
            pass    <= 1'b0;
         end else begin
            idle_cnt <= idle_cnt + 1'b1;
         end
      end
   end
endmodule
